// File: rtl/tt_cmd_responder.sv
// Byte-wide command responder: 16 x 8-bit register file reached through a
// four-phase strobe/ack handshake on a synchronized host strobe.
module tt_cmd_responder #(
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD_ACK   = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_DATA_ACK  = 3'd3,
        S_READ_ACK  = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_ack;
    logic            r_ack_o;
    logic            r_err;
    logic [7:0]      r_uo;
    logic [7:0]      r_cmd;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_regs [0:15];

    logic            w_strb_s;
    logic            w_new_rsv;
    logic [3:0]      w_new_addr;
    logic [7:0]      w_rd_data;
    logic            w_unused_bits;

    assign w_strb_s      = r_sync2;
    assign w_new_rsv     = |ui_in[6:4];
    assign w_new_addr    = ui_in[3:0];
    assign w_unused_bits = &{1'b0, uio_in[7:1]};

    // Read mux for a command being accepted this cycle; reg 15 is the ID constant.
    always_comb begin
        w_rd_data = 8'h00;
        if (w_new_rsv) begin
            w_rd_data = 8'h00;
        end else if (w_new_addr == 4'd15) begin
            w_rd_data = ID_VALUE;
        end else begin
            w_rd_data = r_regs[w_new_addr];
        end
    end

    // Two-flop synchronizer for the asynchronous host strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= uio_in[0];
            r_sync2 <= r_sync1;
        end
    end

    // Handshake FSM with register file; ack passes through one extra output flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_ack_o <= 1'b0;
            r_err   <= 1'b0;
            r_uo    <= 8'h00;
            r_cmd   <= 8'h00;
            r_cnt   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (!ena) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_ack_o <= 1'b0;
        end else begin
            r_ack_o <= r_ack;
            case (r_state)
                S_IDLE: begin
                    if (w_strb_s) begin
                        r_cmd <= ui_in;
                        r_err <= w_new_rsv;
                        r_ack <= 1'b1;
                        if (ui_in[7]) begin
                            r_state <= S_CMD_ACK;
                        end else begin
                            r_uo    <= w_rd_data;
                            r_state <= S_READ_ACK;
                        end
                    end
                end
                S_CMD_ACK: begin
                    if (!w_strb_s) begin
                        r_ack   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (w_strb_s) begin
                        // Reserved-bit commands and the ID register swallow the data byte.
                        if (!(|r_cmd[6:4]) && (r_cmd[3:0] != 4'd15)) begin
                            r_regs[r_cmd[3:0]] <= ui_in;
                        end
                        r_ack   <= 1'b1;
                        r_state <= S_DATA_ACK;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA_ACK, S_READ_ACK: begin
                    if (!w_strb_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign uo_out  = r_uo;
    assign uio_out = {5'b0_0000, r_err, r_ack_o, 1'b0};
    assign uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_tt_cmd_responder.sv
// Self-checking bench for tt_cmd_responder: scenario tasks with a reference
// register model and a scoreboard queue of expected read bytes.
module tb_tt_cmd_responder;

    localparam int         T_OUT = 16;
    localparam logic [7:0] ID    = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         ack_toggles = 0;
    logic [7:0] model [0:15];
    logic [7:0] sb_q [$];
    logic [7:0] last_read;

    tt_cmd_responder #(.TIMEOUT(T_OUT), .ID_VALUE(ID)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(uio_out[1]) ack_toggles++;

    function automatic logic [7:0] exp_read(input logic [7:0] cmd);
        if (cmd[6:4] != 3'd0) return 8'h00;
        if (cmd[3:0] == 4'd15) return ID;
        return model[cmd[3:0]];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        last_read = 8'h00;
    endtask

    // One four-phase handshake; pops the scoreboard on a read once ack is seen.
    task automatic handshake(input logic [7:0] b, input bit is_read);
        bit         seen;
        logic [7:0] exp;
        ui_in  = b;
        uio_in = 8'hF1;
        seen   = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            if (uio_out[1] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL ack_rise byte=%h ack=%b required 1", b, uio_out[1]);
        else n_pass++;
        if (is_read) begin
            exp = sb_q.pop_front();
            n_checks++;
            if (uo_out !== exp) $display("FAIL read_data cmd=%h uo_out=%h required %h", b, uo_out, exp);
            else n_pass++;
        end
        uio_in = 8'hF0;
        seen   = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            if (uio_out[1] === 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL ack_fall byte=%h ack=%b required 0", b, uio_out[1]);
        else n_pass++;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] data);
        handshake(cmd, 1'b0);
        handshake(data, 1'b0);
        if (cmd[6:4] == 3'd0 && cmd[3:0] != 4'd15) model[cmd[3:0]] = data;
    endtask

    task automatic do_read(input logic [7:0] cmd);
        sb_q.push_back(exp_read(cmd));
        last_read = exp_read(cmd);
        handshake(cmd, 1'b1);
    endtask

    task automatic test_reset();
        ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00)
            $display("FAIL reset_out uo_out=%h uio_out=%h required 00/00", uo_out, uio_out);
        else n_pass++;
        n_checks++;
        if (uio_oe !== 8'h06) $display("FAIL reset_oe uio_oe=%h required 06", uio_oe);
        else n_pass++;
        rst_n = 1'b1;
        clear_model();
        do_read(8'h07);
    endtask

    task automatic test_write_read();
        int t0;
        t0 = ack_toggles;
        do_write(8'h83, 8'h5C);
        n_checks++;
        if (ack_toggles - t0 !== 4) $display("FAIL write_toggles got=%0d required 4", ack_toggles - t0);
        else n_pass++;
        do_read(8'h03);
        n_checks++;
        if (uio_out[2] !== 1'b0) $display("FAIL write_read_err err=%b required 0", uio_out[2]);
        else n_pass++;
    endtask

    task automatic test_id_reg();
        do_read(8'h0F);
        do_write(8'h8F, 8'h00);
        do_read(8'h0F);
    endtask

    task automatic test_timeout();
        handshake(8'h82, 1'b0);
        repeat (T_OUT - 2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (uio_out[2] !== 1'b0) $display("FAIL timeout_early err=%b required 0", uio_out[2]);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (uio_out[2] !== 1'b1) $display("FAIL timeout_err err=%b required 1", uio_out[2]);
        else n_pass++;
        do_read(8'h02);
        n_checks++;
        if (uio_out[2] !== 1'b0) $display("FAIL timeout_clear err=%b required 0", uio_out[2]);
        else n_pass++;
    endtask

    task automatic test_reserved();
        do_read(8'h03);
        do_write(8'h93, 8'h77);
        n_checks++;
        if (uio_out[2] !== 1'b1) $display("FAIL rsv_write_err err=%b required 1", uio_out[2]);
        else n_pass++;
        do_read(8'h15);
        n_checks++;
        if (uio_out[2] !== 1'b1) $display("FAIL rsv_read_err err=%b required 1", uio_out[2]);
        else n_pass++;
        do_read(8'h03);
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        ui_in = 8'h0F; uio_in = 8'h01;
        sb_q.push_back(ID);
        last_read = ID;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (uio_out[1] !== 1'b0 || uio_oe !== 8'h06)
                $display("FAIL lat_rise_%0d ack=%b oe=%h required 0/06", k, uio_out[1], uio_oe);
            else n_pass++;
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (uio_out[1] !== 1'b1) $display("FAIL lat_rise_3 ack=%b required 1", uio_out[1]);
        else n_pass++;
        n_checks++;
        if (uo_out !== sb_q.pop_front()) $display("FAIL lat_data uo_out=%h required %h", uo_out, ID);
        else n_pass++;
        uio_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (uio_out[1] !== 1'b1) $display("FAIL lat_fall_%0d ack=%b required 1", k, uio_out[1]);
            else n_pass++;
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (uio_out[1] !== 1'b0 || uio_oe !== 8'h06)
            $display("FAIL lat_fall_3 ack=%b oe=%h required 0/06", uio_out[1], uio_oe);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_write(8'h84, 8'h9E);
        handshake(8'h84, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (uio_out[1] !== 1'b0 || uo_out !== 8'h00)
            $display("FAIL mid_reset ack=%b uo_out=%h required 0/00", uio_out[1], uo_out);
        else n_pass++;
        rst_n = 1'b1;
        clear_model();
        do_read(8'h04);
    endtask

    task automatic test_ena();
        bit seen;
        do_write(8'h85, 8'h3C);
        ui_in = 8'h05; uio_in = 8'h01;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            if (uio_out[1] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL ena_ack_rise ack=%b required 1", uio_out[1]);
        else n_pass++;
        ena = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (uio_out[1] !== 1'b0 || uo_out !== 8'h3C)
            $display("FAIL ena_off ack=%b uo_out=%h required 0/3c", uio_out[1], uo_out);
        else n_pass++;
        uio_in = 8'h00;
        repeat (4) @(posedge clk);
        ena = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (uio_out[1] !== 1'b0) $display("FAIL ena_resume ack=%b required 0", uio_out[1]);
        else n_pass++;
        do_read(8'h05);
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            a = 4'($urandom_range(0, 14));
            d = 8'($urandom_range(1, 255));
            do_write({4'h8, a}, d);
            n_checks++;
            if (uo_out !== last_read) $display("FAIL b2b_hold uo_out=%h required %h", uo_out, last_read);
            else n_pass++;
            do_read({4'h0, a});
            do_read({4'h0, 4'(i)});
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        clear_model();
        test_reset();
        test_write_read();
        test_id_reg();
        test_timeout();
        test_reserved();
        test_latency();
        test_reset_mid();
        test_ena();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
